// File: rtl/proj_qsys_nios_jtag_ocimem_if.sv
// rtl/proj_qsys_nios_jtag_ocimem_if.sv - Avalon-MM slave bundle for the CPU side of the debug memory
interface proj_qsys_nios_jtag_ocimem_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W:0] address;
    logic            read;
    logic            write;
    logic [31:0]     writedata;
    logic [3:0]      byteenable;
    logic [31:0]     readdata;
    logic            readdatavalid;
    logic            waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/proj_qsys_nios_jtag_ocimem.sv
// rtl/proj_qsys_nios_jtag_ocimem.sv - JTAG debug RAM with auto-increment address and CPU monitor port
module proj_qsys_nios_jtag_ocimem #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    proj_qsys_nios_jtag_ocimem_if.slave avs,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic        monitor_go
);
    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       ram_q;
    logic [ADDR_W-1:0] mon_a_reg;
    logic [ADDR_W-1:0] mon_a_inc;
    logic [ADDR_W-1:0] jrd_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ready, error, go;
    logic              jrd_pend;
    logic              rd_valid, rd_ctl;
    logic [31:0]       ctl_q;

    logic jwr, act_a, jnext, jload, jrd, jtag_busy;
    logic cpu_ram_sel, cpu_rd_acc, cpu_wr_acc, ctl_wr;
    logic unused;

    // Strobe priority: a write masks both action_a and read-next.
    assign jwr       = take_action_ocimem_b;
    assign act_a     = take_action_ocimem_a & ~jwr;
    assign jnext     = take_no_action_ocimem_a & ~jwr & ~take_action_ocimem_a;
    assign jload     = act_a & jdo[33];
    assign jrd       = jload | jnext;
    assign jtag_busy = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

    assign mon_a_inc = mon_a_reg + ADDR_W'(1);
    assign jrd_addr  = jload ? jdo[17 +: ADDR_W] : mon_a_inc;

    assign cpu_ram_sel     = ~avs.address[ADDR_W];
    assign avs.waitrequest = (avs.read | avs.write) & cpu_ram_sel & jtag_busy;
    assign cpu_rd_acc      = avs.read & ~avs.waitrequest;
    assign cpu_wr_acc      = avs.write & ~avs.waitrequest & cpu_ram_sel;
    assign ctl_wr          = avs.write & avs.address[ADDR_W];

    assign ram_addr = jtag_busy ? (jwr ? mon_a_reg : jrd_addr) : avs.address[ADDR_W-1:0];

    assign avs.readdata      = rd_valid ? (rd_ctl ? ctl_q : ram_q) : 32'h0;
    assign avs.readdatavalid = rd_valid;

    assign monitor_ready = ready;
    assign monitor_error = error;
    assign monitor_go    = go;

    assign unused = &{1'b0, jdo[37:36], jdo[2:0]};

    // Single-ported RAM; JTAG and CPU never both reach it in one cycle.
    always_ff @(posedge clk) begin
        if (jwr) begin
            mem[mon_a_reg] <= jdo[34:3];
        end else if (cpu_wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (avs.byteenable[b]) begin
                    mem[ram_addr][8*b +: 8] <= avs.writedata[8*b +: 8];
                end
            end
        end
        ram_q <= mem[ram_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_a_reg <= '0;
            MonDReg   <= 32'h0;
            jrd_pend  <= 1'b0;
            ready     <= 1'b0;
            error     <= 1'b0;
            go        <= 1'b0;
            rd_valid  <= 1'b0;
            rd_ctl    <= 1'b0;
            ctl_q     <= 32'h0;
        end else begin
            jrd_pend <= jrd;
            if (jrd_pend) begin
                MonDReg <= ram_q;
            end

            if (jwr || jnext) begin
                mon_a_reg <= mon_a_inc;
            end else if (jload) begin
                mon_a_reg <= jdo[17 +: ADDR_W];
            end

            rd_valid <= cpu_rd_acc;
            rd_ctl   <= avs.address[ADDR_W];
            ctl_q    <= {29'b0, go, error, ready};

            // Sets are applied last so they win over same-cycle clears.
            if (act_a && jdo[34]) begin
                ready <= 1'b0;
                error <= 1'b0;
            end
            if (ctl_wr && avs.writedata[0]) ready <= 1'b1;
            if (ctl_wr && avs.writedata[1]) error <= 1'b1;
            if (ctl_wr && avs.writedata[2]) go <= 1'b0;
            if (act_a && jdo[35]) go <= 1'b1;
        end
    end
endmodule

// File: tb/tb_proj_qsys_nios_jtag_ocimem.sv
// tb/tb_proj_qsys_nios_jtag_ocimem.sv - self-checking bench for the JTAG debug memory
module tb_proj_qsys_nios_jtag_ocimem;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, monitor_go;

    proj_qsys_nios_jtag_ocimem_if #(.ADDR_W(8)) avs ();

    proj_qsys_nios_jtag_ocimem #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .avs                     (avs),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .monitor_go              (monitor_go)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_vec_t;

    int          tests = 0;
    int          failed = 0;
    logic [31:0] model [256];
    logic [31:0] exp_q [$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [37:0] jload(input logic [7:0] a);
        return (38'h1 << 33) | ({30'b0, a} << 17);
    endfunction

    function automatic logic [37:0] jdata(input logic [31:0] d);
        return {3'b0, d, 3'b0};
    endfunction

    always @(negedge clk) begin
        if (reset_n && avs.readdatavalid) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL rd_spurious: readdatavalid with data %h, none expected", avs.readdata);
            end else begin
                chk("rd_data", avs.readdata, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jtag(input logic a, input logic na, input logic b, input logic [37:0] d);
        jdo = d;
        take_action_ocimem_a = a;
        take_no_action_ocimem_a = na;
        take_action_ocimem_b = b;
        tick();
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic wait_accept(input string name);
        int n = 0;
        @(negedge clk);
        while (avs.waitrequest && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n == 8) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
        avs.address = a;
        avs.writedata = d;
        avs.byteenable = be;
        avs.write = 1'b1;
        wait_accept("wr");
        tick();
        avs.write = 1'b0;
        if (!a[8]) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[a[7:0]][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic cpu_read(input logic [8:0] a, input logic [31:0] exp);
        avs.address = a;
        avs.read = 1'b1;
        wait_accept("rd");
        exp_q.push_back(exp);
        tick();
        avs.read = 1'b0;
        @(negedge clk);
        chk("rd_latency", {31'b0, avs.readdatavalid}, 32'd1);
        tick();
    endtask

    wr_vec_t vecs [6];

    initial begin
        vecs[0] = '{9'h020, 32'h11223344, 4'hF};
        vecs[1] = '{9'h021, 32'hAABBCCDD, 4'hF};
        vecs[2] = '{9'h020, 32'hFFFFFFFF, 4'h5};
        vecs[3] = '{9'h021, 32'h00000000, 4'hA};
        vecs[4] = '{9'h07F, 32'h5A5AA5A5, 4'hF};
        vecs[5] = '{9'h07F, 32'h12345678, 4'h8};

        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avs.address = '0;
        avs.read = 1'b0;
        avs.write = 1'b0;
        avs.writedata = '0;
        avs.byteenable = '0;
        repeat (3) tick();
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_flags", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h0);
        chk("rst_rdvalid", {31'b0, avs.readdatavalid}, 32'h0);
        chk("rst_readdata", avs.readdata, 32'h0);
        reset_n = 1'b1;
        tick();

        // Byte-lane table through the scoreboard.
        foreach (vecs[i]) cpu_write(vecs[i].addr, vecs[i].data, vecs[i].be);
        foreach (vecs[i]) cpu_read(vecs[i].addr, model[vecs[i].addr[7:0]]);

        // JTAG load-and-read with two-cycle latency.
        cpu_write(9'h010, 32'hDEADBEEF, 4'hF);
        jtag(1'b1, 1'b0, 1'b0, jload(8'h10));
        chk("load_early", MonDReg, 32'h0);
        tick();
        chk("load_data", MonDReg, 32'hDEADBEEF);
        tick();
        chk("load_hold", MonDReg, 32'hDEADBEEF);

        // Wrapping writes; write 2 also raises action_a with a go request that must be ignored.
        jtag(1'b1, 1'b0, 1'b0, jload(8'hFF));
        jtag(1'b0, 1'b0, 1'b1, jdata(32'h1));
        jtag(1'b1, 1'b0, 1'b1, jdata(32'h2) | (38'h1 << 35));
        jtag(1'b0, 1'b0, 1'b1, jdata(32'h3));
        jtag(1'b0, 1'b0, 1'b1, jdata(32'h4));
        model[8'hFF] = 32'h1;
        model[8'h00] = 32'h2;
        model[8'h01] = 32'h3;
        model[8'h02] = 32'h4;
        chk("prio_go", {31'b0, monitor_go}, 32'h0);
        cpu_read(9'h0FF, 32'h1);
        cpu_read(9'h000, 32'h2);
        cpu_read(9'h001, 32'h3);
        cpu_read(9'h002, 32'h4);
        jtag(1'b1, 1'b0, 1'b0, jload(8'hFF));
        tick();
        chk("wrap_rd0", MonDReg, 32'h1);
        jtag(1'b0, 1'b1, 1'b0, '0);
        tick();
        chk("wrap_rd1", MonDReg, 32'h2);
        jtag(1'b0, 1'b1, 1'b0, '0);
        tick();
        chk("wrap_rd2", MonDReg, 32'h3);

        // CPU read stalled by a JTAG strobe for exactly one cycle.
        avs.address = 9'h010;
        avs.read = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        chk("wait_hi", {31'b0, avs.waitrequest}, 32'd1);
        tick();
        take_no_action_ocimem_a = 1'b0;
        @(negedge clk);
        chk("wait_lo", {31'b0, avs.waitrequest}, 32'd0);
        exp_q.push_back(32'hDEADBEEF);
        tick();
        avs.read = 1'b0;
        @(negedge clk);
        chk("wait_rdvalid", {31'b0, avs.readdatavalid}, 32'd1);
        tick();

        // CPU set of ready/error beats a same-cycle JTAG clear.
        avs.address = 9'h100;
        avs.writedata = 32'h3;
        avs.write = 1'b1;
        jtag(1'b1, 1'b0, 1'b0, 38'h1 << 34);
        avs.write = 1'b0;
        chk("set_wins", {30'b0, monitor_error, monitor_ready}, 32'h3);
        jtag(1'b1, 1'b0, 1'b0, 38'h1 << 34);
        chk("clear_alone", {30'b0, monitor_error, monitor_ready}, 32'h0);

        // JTAG go set beats a same-cycle CPU clear.
        avs.address = 9'h100;
        avs.writedata = 32'h4;
        avs.write = 1'b1;
        jtag(1'b1, 1'b0, 1'b0, 38'h1 << 35);
        avs.write = 1'b0;
        chk("go_wins", {31'b0, monitor_go}, 32'd1);
        cpu_read(9'h100, 32'h4);
        cpu_write(9'h100, 32'h0, 4'hF);
        chk("ctl_zero_noop", {31'b0, monitor_go}, 32'd1);
        cpu_write(9'h100, 32'h4, 4'hF);
        chk("go_clear", {31'b0, monitor_go}, 32'd0);
        cpu_write(9'h100, 32'h1, 4'hF);
        cpu_read(9'h100, 32'h1);

        // Short reset pulse between a JTAG read strobe and its capture.
        jtag(1'b1, 1'b0, 1'b0, jload(8'h10));
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        chk("rst_drop_mondreg", MonDReg, 32'h0);
        chk("rst_drop_flags", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h0);
        cpu_read(9'h100, 32'h0);
        repeat (2) tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
